// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit for the RISC-V core.
// Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
// Owns the instruction register and the XLEN-wide immediate generator.
// Drives handshaked instruction/data memory requests, a multi-cycle
// multiply and a sticky illegal-instruction trap.
module multicycle_control_unit #(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    input  logic            alu_zero,
    output logic            imem_req,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] imm,
    output logic [3:0]      alu_op,
    output logic [1:0]      alu_src_a,
    output logic            alu_src_b,
    output logic            reg_write,
    output logic [1:0]      wb_sel,
    output logic            pc_we,
    output logic [1:0]      pc_src,
    output logic            illegal
);

    localparam int CNT_W = $clog2(MUL_LAT + 1);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_XOR = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        C_ALU,
        C_MUL,
        C_LOAD,
        C_STORE,
        C_BRANCH,
        C_JAL,
        C_JALR,
        C_LUI,
        C_AUIPC,
        C_BAD
    } iclass_t;

    state_t                  state;
    state_t                  state_n;
    logic [31:0]             ir;
    logic signed [XLEN-1:0]  imm_q;
    logic [CNT_W-1:0]        mul_cnt;

    iclass_t                 iclass;
    logic [3:0]              dec_op;
    logic [1:0]              dec_src_a;
    logic                    dec_src_b;
    logic                    shift_ok;
    logic                    mul_last;
    logic                    br_taken;

    wire [6:0] opcode = ir[6:0];
    wire [2:0] funct3 = ir[14:12];
    wire [6:0] funct7 = ir[31:25];

    // Sign-extended 32-bit immediate for every format; R-type yields zero.
    function automatic logic signed [31:0] imm_of(input logic [31:0] i);
        logic signed [31:0] r;
        case (i[6:0])
            OP_IMM, OP_LOAD, OP_JALR: r = {{20{i[31]}}, i[31:20]};
            OP_STORE:                 r = {{20{i[31]}}, i[31:25], i[11:7]};
            OP_BRANCH:                r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:         r = {i[31:12], 12'b0};
            OP_JAL:                   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:                  r = '0;
        endcase
        return r;
    endfunction

    // Shift-immediate legality: upper bits must be zero; RV64 frees bit 25 for shamt[5].
    assign shift_ok = (ir[31:26] == 6'd0) && ((XLEN == 64) || !ir[25]);
    assign mul_last = (mul_cnt == CNT_W'(MUL_LAT - 1));
    assign br_taken = funct3[0] ? !alu_zero : alu_zero;

    // Classify the instruction in IR and choose its ALU operation and operands.
    always_comb begin
        iclass    = C_BAD;
        dec_op    = ALU_ADD;
        dec_src_a = 2'd0;
        dec_src_b = 1'b0;
        case (opcode)
            OP_REG: begin
                case (funct3)
                    3'b000: begin
                        if (funct7 == F7_BASE) begin
                            iclass = C_ALU; dec_op = ALU_ADD;
                        end else if (funct7 == F7_ALT) begin
                            iclass = C_ALU; dec_op = ALU_SUB;
                        end else if (funct7 == F7_MUL) begin
                            iclass = C_MUL; dec_op = ALU_MUL;
                        end
                    end
                    3'b111: if (funct7 == F7_BASE) begin iclass = C_ALU; dec_op = ALU_AND; end
                    3'b110: if (funct7 == F7_BASE) begin iclass = C_ALU; dec_op = ALU_OR;  end
                    3'b100: if (funct7 == F7_BASE) begin iclass = C_ALU; dec_op = ALU_XOR; end
                    3'b001: if (funct7 == F7_BASE) begin iclass = C_ALU; dec_op = ALU_SLL; end
                    3'b101: if (funct7 == F7_BASE) begin iclass = C_ALU; dec_op = ALU_SRL; end
                    default: iclass = C_BAD;
                endcase
            end
            OP_IMM: begin
                dec_src_b = 1'b1;
                case (funct3)
                    3'b000: begin iclass = C_ALU; dec_op = ALU_ADD; end
                    3'b100: begin iclass = C_ALU; dec_op = ALU_XOR; end
                    3'b110: begin iclass = C_ALU; dec_op = ALU_OR;  end
                    3'b111: begin iclass = C_ALU; dec_op = ALU_AND; end
                    3'b001: if (shift_ok) begin iclass = C_ALU; dec_op = ALU_SLL; end
                    3'b101: if (shift_ok) begin iclass = C_ALU; dec_op = ALU_SRL; end
                    default: iclass = C_BAD;
                endcase
            end
            OP_LOAD: begin
                if (funct3 == 3'b010) iclass = C_LOAD;
                dec_src_b = 1'b1;
            end
            OP_STORE: begin
                if (funct3 == 3'b010) iclass = C_STORE;
                dec_src_b = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000 || funct3 == 3'b001) iclass = C_BRANCH;
                dec_op = ALU_SUB;
            end
            OP_JAL: begin
                iclass    = C_JAL;
                dec_src_a = 2'd1;
                dec_src_b = 1'b1;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) iclass = C_JALR;
                dec_src_b = 1'b1;
            end
            OP_LUI: begin
                iclass    = C_LUI;
                dec_src_a = 2'd2;
                dec_src_b = 1'b1;
            end
            OP_AUIPC: begin
                iclass    = C_AUIPC;
                dec_src_a = 2'd1;
                dec_src_b = 1'b1;
            end
            default: iclass = C_BAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // Instruction register captures the fetched word only on the FETCH handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                   ir <= '0;
        else if (state == S_FETCH && imem_ready)   ir <= imem_rdata;
    end

    // Immediate is latched once in DECODE and held for the rest of the instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     imm_q <= '0;
        else if (state == S_DECODE)  imm_q <= XLEN'(imm_of(ir));
    end

    // Multiply latency counter runs only while a MUL sits in EXEC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       mul_cnt <= '0;
        else if (state == S_EXEC && iclass == C_MUL)   mul_cnt <= mul_last ? '0 : mul_cnt + 1'b1;
        else                                           mul_cnt <= '0;
    end

    // Next-state and output decode from state and IR.
    always_comb begin
        state_n   = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        rs1       = '0;
        rs2       = '0;
        rd        = '0;
        imm       = '0;
        alu_op    = ALU_ADD;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        pc_we     = 1'b0;
        pc_src    = 2'd0;
        illegal   = 1'b0;

        // Register fields and immediate are blanked while idle or trapped.
        if (state != S_IDLE && state != S_TRAP) begin
            rs1 = ir[19:15];
            rs2 = ir[24:20];
            rd  = ir[11:7];
            imm = imm_q;
        end

        // ALU controls stay up through MEM and WB so address and result remain valid.
        if (state == S_EXEC || state == S_MEM || state == S_WB) begin
            alu_op    = dec_op;
            alu_src_a = dec_src_a;
            alu_src_b = dec_src_b;
        end

        case (state)
            S_IDLE: state_n = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_n = S_DECODE;
            end
            S_DECODE: state_n = (iclass == C_BAD) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (iclass)
                    C_LOAD, C_STORE: state_n = S_MEM;
                    C_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_src  = br_taken ? 2'd1 : 2'd0;
                        state_n = S_FETCH;
                    end
                    C_MUL: if (mul_last) state_n = S_WB;
                    default: state_n = S_WB;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (iclass == C_STORE);
                if (dmem_ready) begin
                    if (iclass == C_STORE) begin
                        pc_we   = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write = (ir[11:7] != 5'd0);
                pc_we     = 1'b1;
                case (iclass)
                    C_LOAD:  wb_sel = 2'd1;
                    C_JAL:   begin wb_sel = 2'd2; pc_src = 2'd1; end
                    C_JALR:  begin wb_sel = 2'd2; pc_src = 2'd2; end
                    default: wb_sel = 2'd0;
                endcase
                state_n = S_FETCH;
            end
            S_TRAP: illegal = 1'b1;
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: 32- and 64-bit instances share
// stimulus; per-cycle expected outputs are queued and compared on the falling edge.
module tb_multicycle_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_rdata;
    logic        imem_ready, dmem_ready, alu_zero;

    logic        a_ireq, a_dreq, a_dwe, a_rw, a_pw, a_ill, a_sb;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [31:0] a_imm;
    logic [3:0]  a_op;
    logic [1:0]  a_sa, a_ws, a_ps;

    logic        b_ireq, b_dreq, b_dwe, b_rw, b_pw, b_ill, b_sb;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [63:0] b_imm;
    logic [3:0]  b_op;
    logic [1:0]  b_sa, b_ws, b_ps;

    typedef struct {
        string       tag;
        logic [16:0] exp;
        logic        chk;
        logic [4:0]  rd;
        logic [63:0] imm;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    localparam logic [31:0] XX = 32'hFFFF_FFFF;

    always #5 clk = ~clk;

    multicycle_control_unit #(.XLEN(32), .MUL_LAT(3)) dut32 (
        .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .alu_zero(alu_zero), .imem_req(a_ireq),
        .dmem_req(a_dreq), .dmem_we(a_dwe), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd),
        .imm(a_imm), .alu_op(a_op), .alu_src_a(a_sa), .alu_src_b(a_sb),
        .reg_write(a_rw), .wb_sel(a_ws), .pc_we(a_pw), .pc_src(a_ps), .illegal(a_ill)
    );

    multicycle_control_unit #(.XLEN(64), .MUL_LAT(3)) dut64 (
        .clk(clk), .rst(rst), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_ready(dmem_ready), .alu_zero(alu_zero), .imem_req(b_ireq),
        .dmem_req(b_dreq), .dmem_we(b_dwe), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd),
        .imm(b_imm), .alu_op(b_op), .alu_src_a(b_sa), .alu_src_b(b_sb),
        .reg_write(b_rw), .wb_sel(b_ws), .pc_we(b_pw), .pc_src(b_ps), .illegal(b_ill)
    );

    // Pack expected control outputs in a fixed order.
    function automatic logic [16:0] ov(input logic ireq, input logic dreq, input logic dwe,
                                       input logic [3:0] op, input logic [1:0] sa, input logic sb,
                                       input logic rw, input logic [1:0] ws, input logic pw,
                                       input logic [1:0] ps, input logic ill);
        return {ireq, dreq, dwe, op, sa, sb, rw, ws, pw, ps, ill};
    endfunction

    wire [16:0] obs32 = {a_ireq, a_dreq, a_dwe, a_op, a_sa, a_sb, a_rw, a_ws, a_pw, a_ps, a_ill};
    wire [16:0] obs64 = {b_ireq, b_dreq, b_dwe, b_op, b_sa, b_sb, b_rw, b_ws, b_pw, b_ps, b_ill};

    // Drive one cycle of inputs and queue what the outputs must be during it.
    task automatic cyc(input string tag, input logic [31:0] rdata, input logic irdy,
                       input logic drdy, input logic z, input logic [16:0] e,
                       input logic chk, input logic [4:0] erd, input logic [63:0] eimm);
        exp_t item;
        imem_rdata = rdata;
        imem_ready = irdy;
        dmem_ready = drdy;
        alu_zero   = z;
        item.tag = tag;
        item.exp = e;
        item.chk = chk;
        item.rd  = erd;
        item.imm = eimm;
        sbq.push_back(item);
        @(posedge clk);
        #1;
    endtask

    // Pop one expectation per falling edge and compare both instances.
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            cur = sbq.pop_front();
            total++;
            assert (obs32 === cur.exp) else begin
                bad++;
                $error("FAIL %s ctl32 got=%h exp=%h", cur.tag, obs32, cur.exp);
            end
            total++;
            assert (obs64 === cur.exp) else begin
                bad++;
                $error("FAIL %s ctl64 got=%h exp=%h", cur.tag, obs64, cur.exp);
            end
            if (cur.chk) begin
                total++;
                assert (a_rd === cur.rd && b_rd === cur.rd) else begin
                    bad++;
                    $error("FAIL %s rd got=%0d/%0d exp=%0d", cur.tag, a_rd, b_rd, cur.rd);
                end
                total++;
                assert (a_imm === cur.imm[31:0]) else begin
                    bad++;
                    $error("FAIL %s imm32 got=%h exp=%h", cur.tag, a_imm, cur.imm[31:0]);
                end
                total++;
                assert (b_imm === cur.imm) else begin
                    bad++;
                    $error("FAIL %s imm64 got=%h exp=%h", cur.tag, b_imm, cur.imm);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; imem_rdata = '0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;
        @(posedge clk);
        #1;
        cyc("reset", 32'h0, 0, 0, 0, '0, 1, 5'd0, 64'd0);
        rst = 1'b0;
        cyc("idle", 32'h0, 0, 0, 0, '0, 1, 5'd0, 64'd0);

        // add x3,x1,x2; stray ready outside FETCH/MEM must be ignored
        cyc("add_fetch", 32'h002081B3, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("add_dec",   XX, 1, 1, 0, '0, 0, 0, 0);
        cyc("add_exec",  XX, 1, 1, 0, '0, 1, 5'd3, 64'd0);
        cyc("add_wb",    XX, 1, 1, 0, ov(0,0,0,0,0,0,1,0,1,0,0), 1, 5'd3, 64'd0);

        // add x0,x1,x2: write-back suppressed, PC still advances
        cyc("x0_fetch", 32'h00208033, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("x0_dec",   XX, 0, 0, 0, '0, 0, 0, 0);
        cyc("x0_exec",  XX, 0, 0, 0, '0, 1, 5'd0, 64'd0);
        cyc("x0_wb",    XX, 0, 0, 0, ov(0,0,0,0,0,0,0,0,1,0,0), 1, 5'd0, 64'd0);

        // lw x1,-4(x2) with two data wait cycles
        cyc("lw_fetch", 32'hFFC12083, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("lw_dec",   XX, 0, 0, 0, '0, 0, 0, 0);
        cyc("lw_exec",  XX, 0, 0, 0, ov(0,0,0,0,0,1,0,0,0,0,0), 1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc("lw_mem0",  XX, 0, 0, 0, ov(0,1,0,0,0,1,0,0,0,0,0), 0, 0, 0);
        cyc("lw_mem1",  XX, 0, 0, 0, ov(0,1,0,0,0,1,0,0,0,0,0), 0, 0, 0);
        cyc("lw_mem2",  XX, 0, 1, 0, ov(0,1,0,0,0,1,0,0,0,0,0), 0, 0, 0);
        cyc("lw_wb",    XX, 0, 0, 0, ov(0,0,0,0,0,1,1,1,1,0,0), 1, 5'd1, 64'hFFFF_FFFF_FFFF_FFFC);

        // sw x2,8(x1) with one instruction wait cycle, zero-wait data
        cyc("sw_fetch0", 32'h0020A423, 0, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("sw_fetch1", 32'h0020A423, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("sw_dec",    XX, 0, 0, 0, '0, 0, 0, 0);
        cyc("sw_exec",   XX, 0, 0, 0, ov(0,0,0,0,0,1,0,0,0,0,0), 1, 5'd8, 64'd8);
        cyc("sw_mem",    XX, 0, 1, 0, ov(0,1,1,0,0,1,0,0,1,0,0), 0, 0, 0);

        // bne x1,x2,-4 taken, then not taken
        cyc("bne_t_fetch", 32'hFE209EE3, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("bne_t_dec",   XX, 0, 0, 0, '0, 0, 0, 0);
        cyc("bne_t_exec",  XX, 0, 0, 0, ov(0,0,0,1,0,0,0,0,1,1,0), 1, 5'd29, 64'hFFFF_FFFF_FFFF_FFFC);
        cyc("bne_n_fetch", 32'hFE209EE3, 1, 0, 1, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("bne_n_dec",   XX, 0, 0, 1, '0, 0, 0, 0);
        cyc("bne_n_exec",  XX, 0, 0, 1, ov(0,0,0,1,0,0,0,0,1,0,0), 1, 5'd29, 64'hFFFF_FFFF_FFFF_FFFC);

        // mul x3,x1,x2: three EXEC cycles then WB
        cyc("mul_fetch", 32'h022081B3, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("mul_dec",   XX, 0, 0, 0, '0, 0, 0, 0);
        cyc("mul_ex1",   XX, 0, 0, 0, ov(0,0,0,2,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("mul_ex2",   XX, 0, 0, 0, ov(0,0,0,2,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("mul_ex3",   XX, 0, 0, 0, ov(0,0,0,2,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("mul_wb",    XX, 0, 0, 0, ov(0,0,0,2,0,0,1,0,1,0,0), 1, 5'd3, 64'd0);

        // jalr x1,4(x2)
        cyc("jalr_fetch", 32'h004100E7, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("jalr_dec",   XX, 0, 0, 0, '0, 0, 0, 0);
        cyc("jalr_exec",  XX, 0, 0, 0, ov(0,0,0,0,0,1,0,0,0,0,0), 1, 5'd1, 64'd4);
        cyc("jalr_wb",    XX, 0, 0, 0, ov(0,0,0,0,0,1,1,2,1,2,0), 1, 5'd1, 64'd4);

        // lui x5,0x12345
        cyc("lui_fetch", 32'h123452B7, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("lui_dec",   XX, 0, 0, 0, '0, 0, 0, 0);
        cyc("lui_exec",  XX, 0, 0, 0, ov(0,0,0,0,2,1,0,0,0,0,0), 1, 5'd5, 64'h0000_0000_1234_5000);
        cyc("lui_wb",    XX, 0, 0, 0, ov(0,0,0,0,2,1,1,0,1,0,0), 1, 5'd5, 64'h0000_0000_1234_5000);

        // jal x1,-1MiB: most negative J immediate
        cyc("jal_fetch", 32'h800000EF, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("jal_dec",   XX, 0, 0, 0, '0, 0, 0, 0);
        cyc("jal_exec",  XX, 0, 0, 0, ov(0,0,0,0,1,1,0,0,0,0,0), 1, 5'd1, 64'hFFFF_FFFF_FFF0_0000);
        cyc("jal_wb",    XX, 0, 0, 0, ov(0,0,0,0,1,1,1,2,1,1,0), 1, 5'd1, 64'hFFFF_FFFF_FFF0_0000);

        // sw interrupted by reset while waiting on data memory
        cyc("swr_fetch", 32'h0020A423, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("swr_dec",   XX, 0, 0, 0, '0, 0, 0, 0);
        cyc("swr_exec",  XX, 0, 0, 0, ov(0,0,0,0,0,1,0,0,0,0,0), 1, 5'd8, 64'd8);
        cyc("swr_mem",   XX, 0, 0, 0, ov(0,1,1,0,0,1,0,0,0,0,0), 0, 0, 0);
        rst = 1'b1;
        cyc("swr_rst",   XX, 1, 1, 0, '0, 1, 5'd0, 64'd0);
        rst = 1'b0;
        cyc("swr_idle",  XX, 1, 1, 0, '0, 1, 5'd0, 64'd0);
        cyc("swr_refetch", XX, 0, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);

        // illegal word traps, stays trapped, and only reset clears it
        cyc("trap_fetch", 32'hFFFF_FFFF, 1, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);
        cyc("trap_dec",   XX, 1, 1, 0, '0, 0, 0, 0);
        cyc("trap_0",     XX, 1, 1, 0, ov(0,0,0,0,0,0,0,0,0,0,1), 1, 5'd0, 64'd0);
        cyc("trap_1",     XX, 1, 1, 0, ov(0,0,0,0,0,0,0,0,0,0,1), 1, 5'd0, 64'd0);
        cyc("trap_2",     XX, 1, 1, 1, ov(0,0,0,0,0,0,0,0,0,0,1), 1, 5'd0, 64'd0);
        rst = 1'b1;
        cyc("trap_rst",   XX, 0, 0, 0, '0, 1, 5'd0, 64'd0);
        rst = 1'b0;
        cyc("trap_idle",  XX, 0, 0, 0, '0, 1, 5'd0, 64'd0);
        cyc("trap_refetch", XX, 0, 0, 0, ov(1,0,0,0,0,0,0,0,0,0,0), 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
